uart_sipo_rx: RTL and testbench
===============================

Name: uart_sipo_rx

Overview:
UART receive-side serial-in/parallel-out deserializer, the receive counterpart of the transmitter PISO. It oversamples the asynchronous `data_rx` line with `baud_clk`, detects and validates the start bit, and shifts in 8 data bits LSB first. It then checks optional odd/even parity and the stop bit, and presents the byte with one-cycle completion and error flags. It feeds the receive holding register of the UART core.

Parameters:
OVERSAMPLE, 16, `baud_clk` ticks per bit period; even, at least 4.
DATA_BITS, 8, data bits per frame.

Ports:
baud_clk  input  1  sampling clock at OVERSAMPLE × baud rate; all logic on the rising edge.
reset  input  1  synchronous, active-high reset.
data_rx  input  1  asynchronous serial line; idles high.
parity_type  input  2  00 = none, 01 = odd, 10 = even, 11 = none.
data_out  output  DATA_BITS  last received byte.
active_flag  output  1  high while a frame is being received.
done_flag  output  1  one-cycle pulse when a frame completes.
parity_error  output  1  parity mismatch on the completed frame.
stop_error  output  1  stop bit sampled low (framing error).

Behaviour:
- Reset values: data_out = 0, all flags = 0, state = IDLE, synchronizer flops = 1, counters = 0.
- Reset asserted at any point, including mid-frame, drops the partial frame. The next cycle is IDLE with no done_flag.
- Input synchronizer:
  - `data_rx` passes through 2 flops before use; rx_s is the synchronized value.
  - All timing below is relative to T, the first cycle in which rx_s = 0 while in IDLE.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - active_flag = 0.
  - rx_s = 0 → START, tick counter cleared.
- START:
  - Count OVERSAMPLE/2 − 1 ticks, then sample at T + OVERSAMPLE/2 − 1 (T+7 at the default).
  - Sample 1 (glitch) → IDLE, no flags.
  - Sample 0 → DATA; latch parity_type for the whole frame; bit index = 0.
  - active_flag = 1 from the cycle after T until the STOP sample.
- DATA:
  - Sample every OVERSAMPLE ticks. Data bit i is sampled at T + 7 + 16·(i+1) at the default.
  - Bits shift in LSB first.
  - After bit DATA_BITS−1: latched parity enabled → PARITY, else → STOP.
- PARITY:
  - Sample at T + 7 + 16·9.
  - Odd: error if the XOR of the 8 data bits and the parity bit is 0.
  - Even: error if that XOR is 1.
- STOP:
  - Sample one bit period after the last data or parity sample.
  - The cycle after the sample:
    - data_out ← shift register (updated even on error);
    - done_flag = 1 for exactly one cycle;
    - parity_error and stop_error updated; both stay 0 when parity is disabled and the stop bit is 1;
    - active_flag = 0;
    - state = IDLE.
- Error flags hold until the next done_flag. They are not sticky across frames.
- The return to IDLE happens mid stop bit, so a start edge arriving right after the stop bit is caught; back-to-back frames need no idle gap.
- Stop sampled 0 → stop_error = 1. Reception then resumes in IDLE, but a new frame is not started until rx_s has been seen high once (no false start from a break/low line).
- parity_type changes mid-frame have no effect until the next START confirmation.
- Counters: tick counter is $clog2(OVERSAMPLE) bits; bit index is $clog2(DATA_BITS+1) bits.
- No wrap-around past the frame end.

Test Plan:
1. parity_type = 00, send 0x4A (line bits 0,0,1,0,1,0,0,1,0,1) → done_flag pulses once at T+152; data_out = 0x4A; both errors = 0; active_flag high T+1..T+151.
2. parity_type = 01, send 0x4A with parity bit 0 → data_out = 0x4A, parity_error = 0. Resend with parity bit 1 → parity_error = 1, done_flag at T+168.
3. parity_type = 10, send 0x5A with parity bit 0 → no error. Resend with parity bit 1 → parity_error = 1.
4. Drive data_rx low for 4 ticks, then high → no active_flag after START abort, no done_flag, state back to IDLE.
5. parity_type = 00, send 0x4A with stop bit 0 held low 40 ticks, then 0xA5 → first frame: stop_error = 1, data_out = 0x4A. Second frame: 0xA5, stop_error = 0.
6. Assert reset at bit 4 of a frame, release, send 0x3C back-to-back twice → only two done_flags, both 0x3C, no flags from the aborted frame.

Source files
------------

// File: rtl/uart_sipo_rx.sv
// UART receive deserializer: 2-flop line synchronizer, mid-bit sampling of start,
// LSB-first data, optional odd/even parity and stop, with one-cycle completion pulse.
//
// state  | meaning
// IDLE   | line idle, waiting for rx_s low (only once the line has been seen high)
// START  | counting to mid start bit, then confirming or rejecting it
// DATA   | sampling DATA_BITS data bits, one per bit period
// PARITY | sampling the parity bit (only when parity enabled for this frame)
// STOP   | sampling the stop bit, then publishing the frame
module uart_sipo_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 baud_clk,
  input  logic                 reset,
  input  logic                 data_rx,
  input  logic [1:0]           parity_type,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 active_flag,
  output logic                 done_flag,
  output logic                 parity_error,
  output logic                 stop_error
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 2);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state, state_nx;
  logic                 sync_q1, rx_s;
  logic [TW-1:0]        tick;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_en, par_odd, par_acc;
  logic                 armed;
  logic                 tick_clr, sample;

  always_ff @(posedge baud_clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    tick_clr = 1'b0;
    sample   = 1'b0;
    unique case (state)
      IDLE: begin
        tick_clr = 1'b1;
        if (!rx_s && armed) state_nx = START;
      end
      START: begin
        if (tick == TICK_MID) begin
          sample   = 1'b1;
          tick_clr = 1'b1;
          state_nx = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (tick == TICK_LAST) begin
          sample   = 1'b1;
          tick_clr = 1'b1;
          if (bit_idx == BIT_LAST) state_nx = par_en ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (tick == TICK_LAST) begin
          sample   = 1'b1;
          tick_clr = 1'b1;
          state_nx = STOP;
        end
      end
      STOP: begin
        if (tick == TICK_LAST) begin
          sample   = 1'b1;
          tick_clr = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign active_flag = (state != IDLE);

  always_ff @(posedge baud_clk) begin
    if (reset) begin
      sync_q1      <= 1'b1;
      rx_s         <= 1'b1;
      tick         <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      par_en       <= 1'b0;
      par_odd      <= 1'b0;
      par_acc      <= 1'b0;
      armed        <= 1'b1;
      data_out     <= '0;
      done_flag    <= 1'b0;
      parity_error <= 1'b0;
      stop_error   <= 1'b0;
    end else begin
      sync_q1   <= data_rx;
      rx_s      <= sync_q1;
      tick      <= tick_clr ? '0 : tick + 1'b1;
      done_flag <= 1'b0;
      if (rx_s) armed <= 1'b1;
      if (sample) begin
        unique case (state)
          START: begin
            if (!rx_s) begin
              par_en  <= (parity_type == 2'b01) || (parity_type == 2'b10);
              par_odd <= (parity_type == 2'b01);
              bit_idx <= '0;
              par_acc <= 1'b0;
            end
          end
          DATA: begin
            shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
            par_acc <= par_acc ^ rx_s;
            bit_idx <= bit_idx + 1'b1;
          end
          PARITY: par_acc <= par_acc ^ rx_s;
          STOP: begin
            data_out     <= shreg;
            done_flag    <= 1'b1;
            parity_error <= par_en & (par_odd ? ~par_acc : par_acc);
            stop_error   <= ~rx_s;
            // a low stop bit means a break/stuck line: wait for high before re-arming
            if (!rx_s) armed <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_sipo_rx.sv
// Directed bench for uart_sipo_rx: frames driven cycle by cycle, outputs sampled on
// the falling edge with expected timing counted from the start-bit drive cycle.
module tb_uart_sipo_rx;

  logic       baud_clk;
  logic       reset;
  logic       data_rx;
  logic [1:0] parity_type;
  logic [7:0] data_out;
  logic       active_flag, done_flag, parity_error, stop_error;

  int n_checks = 0;
  int n_fail   = 0;

  uart_sipo_rx #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .baud_clk     (baud_clk),
    .reset        (reset),
    .data_rx      (data_rx),
    .parity_type  (parity_type),
    .data_out     (data_out),
    .active_flag  (active_flag),
    .done_flag    (done_flag),
    .parity_error (parity_error),
    .stop_error   (stop_error)
  );

  initial baud_clk = 1'b0;
  always #5 baud_clk = ~baud_clk;

  // Start bit driven in cycle 0 reaches rx_s two cycles later (T = cycle 2), so
  // done appears at cycle 154 without parity and 170 with parity.
  task automatic send_frame(input logic [7:0] data, input logic use_par, input logic par_bit,
                            input logic stop_bit, input int stop_len, input int exp_done_c,
                            output int n_done, output int done_c, output logic [7:0] d_at,
                            output logic pe_at, output logic se_at, output int act_bad);
    int len;
    len     = 16 * (use_par ? 10 : 9) + stop_len;
    n_done  = 0;
    done_c  = -1;
    d_at    = 8'h00;
    pe_at   = 1'b0;
    se_at   = 1'b0;
    act_bad = 0;
    for (int c = 0; c < len; c++) begin
      @(posedge baud_clk);
      #1;
      if (c < 16)                      data_rx = 1'b0;
      else if (c < 144)                data_rx = data[(c - 16) / 16];
      else if (use_par && c < 160)     data_rx = par_bit;
      else                             data_rx = stop_bit;
      @(negedge baud_clk);
      if (done_flag) begin
        n_done++;
        if (done_c < 0) begin
          done_c = c;
          d_at   = data_out;
          pe_at  = parity_error;
          se_at  = stop_error;
        end
      end
      if (active_flag !== ((c >= 3) && (c < exp_done_c))) act_bad++;
    end
  endtask

  task automatic drive_idle(input int n, output int n_done, output int n_active);
    n_done   = 0;
    n_active = 0;
    for (int c = 0; c < n; c++) begin
      @(posedge baud_clk);
      #1 data_rx = 1'b1;
      @(negedge baud_clk);
      if (done_flag)   n_done++;
      if (active_flag) n_active++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    data_rx = 1'b1;
    parity_type = 2'b00;
    repeat (4) @(posedge baud_clk);
    #1 reset = 1'b0;
    @(negedge baud_clk);
    n_checks++;
    if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", data_out); end
    n_checks++;
    if ({active_flag, done_flag, parity_error, stop_error} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 0000", {active_flag, done_flag, parity_error, stop_error});
    end
  endtask

  task automatic test_no_parity;
    int nd, dc, ab;
    logic [7:0] d;
    logic pe, se;
    parity_type = 2'b00;
    send_frame(8'h4A, 1'b0, 1'b0, 1'b1, 16, 154, nd, dc, d, pe, se, ab);
    n_checks++;
    if (nd !== 1) begin n_fail++; $display("FAIL np_done_count: got %0d expected 1", nd); end
    n_checks++;
    if (dc !== 154) begin n_fail++; $display("FAIL np_done_time: got %0d expected 154", dc); end
    n_checks++;
    if (d !== 8'h4A) begin n_fail++; $display("FAIL np_data: got %h expected 4a", d); end
    n_checks++;
    if ({pe, se} !== 2'b00) begin n_fail++; $display("FAIL np_errors: got %b expected 00", {pe, se}); end
    n_checks++;
    if (ab !== 0) begin n_fail++; $display("FAIL np_active: %0d wrong cycles expected 0", ab); end
  endtask

  task automatic test_odd_parity;
    int nd, dc, ab;
    logic [7:0] d;
    logic pe, se;
    parity_type = 2'b01;
    send_frame(8'h4A, 1'b1, 1'b0, 1'b1, 16, 170, nd, dc, d, pe, se, ab);
    n_checks++;
    if (d !== 8'h4A || pe !== 1'b0 || se !== 1'b0) begin
      n_fail++;
      $display("FAIL odd_good: got data %h pe %b se %b expected 4a 0 0", d, pe, se);
    end
    send_frame(8'h4A, 1'b1, 1'b1, 1'b1, 16, 170, nd, dc, d, pe, se, ab);
    n_checks++;
    if (pe !== 1'b1) begin n_fail++; $display("FAIL odd_bad_pe: got %b expected 1", pe); end
    n_checks++;
    if (dc !== 170 || nd !== 1) begin
      n_fail++;
      $display("FAIL odd_done: got cycle %0d count %0d expected 170 1", dc, nd);
    end
    n_checks++;
    if (ab !== 0) begin n_fail++; $display("FAIL odd_active: %0d wrong cycles expected 0", ab); end
  endtask

  task automatic test_even_parity;
    int nd, dc, ab;
    logic [7:0] d;
    logic pe, se;
    parity_type = 2'b10;
    send_frame(8'h5A, 1'b1, 1'b0, 1'b1, 16, 170, nd, dc, d, pe, se, ab);
    n_checks++;
    if (d !== 8'h5A || pe !== 1'b0 || dc !== 170) begin
      n_fail++;
      $display("FAIL even_good: got data %h pe %b cycle %0d expected 5a 0 170", d, pe, dc);
    end
    send_frame(8'h5A, 1'b1, 1'b1, 1'b1, 16, 170, nd, dc, d, pe, se, ab);
    n_checks++;
    if (d !== 8'h5A || pe !== 1'b1) begin
      n_fail++;
      $display("FAIL even_bad: got data %h pe %b expected 5a 1", d, pe);
    end
  endtask

  task automatic test_start_glitch;
    int nd, bad_after;
    logic act_mid;
    nd = 0;
    bad_after = 0;
    act_mid = 1'b0;
    parity_type = 2'b00;
    for (int c = 0; c < 40; c++) begin
      @(posedge baud_clk);
      #1 data_rx = (c < 4) ? 1'b0 : 1'b1;
      @(negedge baud_clk);
      if (done_flag) nd++;
      if (c == 5) act_mid = active_flag;
      if (c >= 10 && active_flag) bad_after++;
    end
    n_checks++;
    if (act_mid !== 1'b1) begin n_fail++; $display("FAIL glitch_start_active: got %b expected 1", act_mid); end
    n_checks++;
    if (bad_after !== 0) begin n_fail++; $display("FAIL glitch_abort_active: %0d active cycles expected 0", bad_after); end
    n_checks++;
    if (nd !== 0) begin n_fail++; $display("FAIL glitch_done: got %0d pulses expected 0", nd); end
  endtask

  task automatic test_stop_error;
    int nd, dc, ab, nd_idle, na_idle;
    logic [7:0] d;
    logic pe, se;
    parity_type = 2'b00;
    send_frame(8'h4A, 1'b0, 1'b0, 1'b0, 40, 154, nd, dc, d, pe, se, ab);
    n_checks++;
    if (d !== 8'h4A || se !== 1'b1 || pe !== 1'b0 || nd !== 1) begin
      n_fail++;
      $display("FAIL stop_err_frame: got data %h se %b pe %b count %0d expected 4a 1 0 1", d, se, pe, nd);
    end
    drive_idle(20, nd_idle, na_idle);
    n_checks++;
    if (nd_idle !== 0 || na_idle !== 0) begin
      n_fail++;
      $display("FAIL stop_err_false_start: got done %0d active %0d expected 0 0", nd_idle, na_idle);
    end
    n_checks++;
    if (stop_error !== 1'b1) begin n_fail++; $display("FAIL stop_err_hold: got %b expected 1", stop_error); end
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 16, 154, nd, dc, d, pe, se, ab);
    n_checks++;
    if (d !== 8'hA5 || se !== 1'b0 || dc !== 154) begin
      n_fail++;
      $display("FAIL stop_err_recover: got data %h se %b cycle %0d expected a5 0 154", d, se, dc);
    end
  endtask

  task automatic test_back_to_back;
    int nd, dc, ab, nd_rst;
    logic [7:0] d;
    logic pe, se;
    logic [7:0] partial;
    partial = 8'h3C;
    nd_rst = 0;
    parity_type = 2'b11;
    for (int c = 0; c < 88; c++) begin
      @(posedge baud_clk);
      #1 data_rx = (c < 16) ? 1'b0 : partial[(c - 16) / 16];
    end
    @(posedge baud_clk);
    #1 begin reset = 1'b1; data_rx = 1'b1; end
    @(negedge baud_clk);
    if (done_flag) nd_rst++;
    @(posedge baud_clk);
    #1 reset = 1'b0;
    @(negedge baud_clk);
    if (done_flag) nd_rst++;
    n_checks++;
    if (active_flag !== 1'b0 || nd_rst !== 0 || data_out !== 8'h00) begin
      n_fail++;
      $display("FAIL midframe_reset: got active %b done %0d data %h expected 0 0 00", active_flag, nd_rst, data_out);
    end
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 16, 154, nd, dc, d, pe, se, ab);
    n_checks++;
    if (nd !== 1 || d !== 8'h3C || dc !== 154 || {pe, se} !== 2'b00) begin
      n_fail++;
      $display("FAIL b2b_first: got count %0d data %h cycle %0d err %b expected 1 3c 154 00", nd, d, dc, {pe, se});
    end
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 16, 154, nd, dc, d, pe, se, ab);
    n_checks++;
    if (nd !== 1 || d !== 8'h3C || dc !== 154 || {pe, se} !== 2'b00) begin
      n_fail++;
      $display("FAIL b2b_second: got count %0d data %h cycle %0d err %b expected 1 3c 154 00", nd, d, dc, {pe, se});
    end
    n_checks++;
    if (ab !== 0) begin n_fail++; $display("FAIL b2b_active: %0d wrong cycles expected 0", ab); end
  endtask

  initial begin
    reset = 1'b1;
    data_rx = 1'b1;
    parity_type = 2'b00;
    test_reset;
    test_no_parity;
    test_odd_parity;
    test_even_parity;
    test_start_glitch;
    test_stop_error;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
